// File: rtl/score_display_mux_pkg.sv
// rtl/score_display_mux_pkg.sv - glyphs, digit slots, result states and score helpers for the score display
package score_display_mux_pkg;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  localparam logic [1:0] IDX_P2_ONES = 2'd0;
  localparam logic [1:0] IDX_P2_TENS = 2'd1;
  localparam logic [1:0] IDX_P1_ONES = 2'd2;
  localparam logic [1:0] IDX_P1_TENS = 2'd3;

  // Encodings double as the winner code presented on the port.
  typedef enum logic [1:0] {
    PLAY   = 2'b00,
    P1_WIN = 2'b01,
    P2_WIN = 2'b10,
    DRAW   = 2'b11
  } state_t;

  typedef struct packed {
    logic [3:0] p1_tens;
    logic [3:0] p1_ones;
    logic [3:0] p2_tens;
    logic [3:0] p2_ones;
  } digits_t;

  function automatic logic [6:0] digit_val(input logic [3:0] d);
    return (d > 4'd9) ? 7'd0 : {3'b000, d};
  endfunction

  function automatic logic [6:0] score_of(input logic [3:0] tens, input logic [3:0] ones);
    return digit_val(tens) * 7'd10 + digit_val(ones);
  endfunction

endpackage

// File: rtl/score_display_mux_bcd_to_7seg.sv
// rtl/score_display_mux_bcd_to_7seg.sv - BCD digit to active-low {g,f,e,d,c,b,a} glyph
module bcd_to_7seg
  import score_display_mux_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/score_display_mux.sv
// rtl/score_display_mux.sv - scanned 4-digit score display with latched, flashing match result
// Optional: SCORE_LEADING_ZERO_BLANK_EN blanks any tens digit equal to 0.
module score_display_mux
  import score_display_mux_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000,
  parameter int FLASH_HZ   = 2,
  parameter int WIN_SCORE  = 10
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic [3:0] p1_tens,
  input  logic [3:0] p1_ones,
  input  logic [3:0] p2_tens,
  input  logic [3:0] p2_ones,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int SCAN_DIV  = CLK_HZ / REFRESH_HZ;
  localparam int FLASH_DIV = CLK_HZ / (2 * FLASH_HZ);
  localparam int SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FLASH_W   = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_DIV - 1);
  localparam logic [6:0]         WIN_VAL    = 7'(WIN_SCORE);

  digits_t              digits_q, digits_d;
  state_t               state_q, state_d;
  logic [SCAN_W-1:0]    scan_cnt_q, scan_cnt_d;
  logic [1:0]           idx_q, idx_d;
  logic [FLASH_W-1:0]   flash_cnt_q, flash_cnt_d;
  logic                 flash_phase_q, flash_phase_d;
  logic                 game_over_q, game_over_d;
  logic [1:0]           winner_q, winner_d;
  logic [3:0]           an_q, an_d;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;

  logic [3:0] cur_digit;
  logic [6:0] glyph;
  logic       zero_blank;

  always_comb begin
    cur_digit = digits_q.p2_ones;
    case (idx_q)
      IDX_P2_ONES: cur_digit = digits_q.p2_ones;
      IDX_P2_TENS: cur_digit = digits_q.p2_tens;
      IDX_P1_ONES: cur_digit = digits_q.p1_ones;
      IDX_P1_TENS: cur_digit = digits_q.p1_tens;
      default:     cur_digit = digits_q.p2_ones;
    endcase
  end

  bcd_to_7seg u_bcd_to_7seg (
    .bcd (cur_digit),
    .seg (glyph)
  );

`ifdef SCORE_LEADING_ZERO_BLANK_EN
  assign zero_blank = idx_q[0] && (cur_digit == 4'd0);
`else
  assign zero_blank = 1'b0;
`endif

  always_comb begin
    logic [6:0] p1_score;
    logic [6:0] p2_score;
    logic       p1_hit;
    logic       p2_hit;
    logic       flash_blank;
    logic       blank;

    digits_d      = {p1_tens, p1_ones, p2_tens, p2_ones};
    state_d       = state_q;
    scan_cnt_d    = scan_cnt_q + SCAN_W'(1);
    idx_d         = idx_q;
    flash_cnt_d   = flash_cnt_q;
    flash_phase_d = flash_phase_q;

    p1_score = score_of(digits_q.p1_tens, digits_q.p1_ones);
    p2_score = score_of(digits_q.p2_tens, digits_q.p2_ones);
    p1_hit   = (p1_score >= WIN_VAL);
    p2_hit   = (p2_score >= WIN_VAL);

    if (state_q == PLAY) begin
      if (p1_hit && p2_hit) state_d = DRAW;
      else if (p1_hit)      state_d = P1_WIN;
      else if (p2_hit)      state_d = P2_WIN;
    end
    game_over_d = (state_d != PLAY);
    winner_d    = state_d;

    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 2'd1;
    end

    if (game_over_q) begin
      if (flash_cnt_q == FLASH_LAST) begin
        flash_cnt_d   = '0;
        flash_phase_d = ~flash_phase_q;
      end else begin
        flash_cnt_d = flash_cnt_q + FLASH_W'(1);
      end
    end

    // idx[1] selects the player 1 digits; winner bit 0 is P1, bit 1 is P2.
    flash_blank = game_over_q && flash_phase_q &&
                  (idx_q[1] ? winner_q[0] : winner_q[1]);
    blank = flash_blank || zero_blank;

    an_d  = blank ? 4'hF : ~(4'b0001 << idx_q);
    seg_d = glyph;
    dp_d  = !((idx_q == IDX_P1_ONES) && !blank);
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      digits_q      <= '0;
      state_q       <= PLAY;
      scan_cnt_q    <= '0;
      idx_q         <= 2'd0;
      flash_cnt_q   <= '0;
      flash_phase_q <= 1'b0;
      game_over_q   <= 1'b0;
      winner_q      <= 2'b00;
      an_q          <= 4'hF;
      seg_q         <= SEG_OFF;
      dp_q          <= 1'b1;
    end else begin
      digits_q      <= digits_d;
      state_q       <= state_d;
      scan_cnt_q    <= scan_cnt_d;
      idx_q         <= idx_d;
      flash_cnt_q   <= flash_cnt_d;
      flash_phase_q <= flash_phase_d;
      game_over_q   <= game_over_d;
      winner_q      <= winner_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_score_display_mux.sv
// tb/tb_score_display_mux.sv - bench for score_display_mux: timeline model plus directed literal checks
module tb_score_display_mux;

  logic       clk_100MHz = 1'b0;
  logic       reset      = 1'b1;
  logic [3:0] p1_tens    = 4'd0;
  logic [3:0] p1_ones    = 4'd0;
  logic [3:0] p2_tens    = 4'd0;
  logic [3:0] p2_ones    = 4'd0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       game_over;
  logic [1:0] winner;

  int total = 0;
  int bad   = 0;

`ifdef SCORE_LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  score_display_mux #(
    .CLK_HZ     (1000),
    .REFRESH_HZ (250),
    .FLASH_HZ   (25),
    .WIN_SCORE  (10)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .p1_tens    (p1_tens),
    .p1_ones    (p1_ones),
    .p2_tens    (p2_tens),
    .p2_ones    (p2_ones),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .game_over  (game_over),
    .winner     (winner)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic int score(input logic [3:0] t, input logic [3:0] o);
    int tv, ov;
    tv = (t > 9) ? 0 : int'(t);
    ov = (o > 9) ? 0 : int'(o);
    return tv * 10 + ov;
  endfunction

  // h = {p1_tens, p1_ones, p2_tens, p2_ones}; result bit0 = P1 reached 10, bit1 = P2.
  function automatic logic [1:0] win_of(input logic [15:0] h);
    return {score(h[7:4], h[3:0]) >= 10, score(h[15:12], h[11:8]) >= 10};
  endfunction

  // Inputs seen at each clock edge since the last reset edge (index 0 = reset edge).
  logic [15:0] hist [0:4095];
  int          k     = 0;
  bit          rst_e = 1'b0;
  bit          seen  = 1'b0;

  always @(posedge clk_100MHz) begin
    seen <= 1'b1;
    if (reset) begin
      k       <= 0;
      rst_e   <= 1'b1;
      hist[0] <= 16'h0000;
    end else begin
      k           <= k + 1;
      rst_e       <= 1'b0;
      hist[k + 1] <= {p1_tens, p1_ones, p2_tens, p2_ones};
    end
  end

  always @(negedge clk_100MHz) begin
    int          jw, pe, idx;
    logic [1:0]  wv;
    logic [3:0]  d;
    logic [15:0] h;
    bit          blank;
    if (seen) begin
      if (rst_e) begin
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_dp", dp, 1'b1);
        chk("rst_go", game_over, 1'b0);
        chk("rst_win", winner, 2'b00);
      end else begin
        jw = -1;
        wv = 2'b00;
        for (int j = 0; j < k; j++) begin
          if (jw < 0 && win_of(hist[j]) != 2'b00) begin
            jw = j;
            wv = win_of(hist[j]);
          end
        end
        pe    = k - 1;
        idx   = (pe / 4) % 4;
        h     = hist[pe];
        d     = 4'(h >> (4 * idx));
        blank = 1'b0;
        if (jw >= 0 && pe >= jw + 1 && ((pe - jw - 1) / 20) % 2 == 1)
          blank = (idx >= 2) ? wv[0] : wv[1];
        if (LZB && (idx % 2 == 1) && d == 4'd0)
          blank = 1'b1;
        chk("m_an", an, blank ? 4'hF : 4'(~(4'b0001 << idx)));
        chk("m_seg", seg, glyph_of(d));
        chk("m_dp", dp, (idx == 2 && !blank) ? 1'b0 : 1'b1);
        chk("m_go", game_over, jw >= 0);
        chk("m_win", winner, (jw >= 0) ? wv : 2'b00);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_100MHz);
  endtask

  task automatic wait_an(input logic [3:0] v, input string nm);
    int n;
    n = 0;
    while (an !== v && n < 40) begin
      @(negedge clk_100MHz);
      n++;
    end
    if (an !== v) chk({nm, "_timeout"}, an, v);
  endtask

  initial begin
    int lows;
    cyc(3);
    chk("lit_rst_an", an, 4'hF);
    chk("lit_rst_seg", seg, 7'h7F);
    reset = 1'b0;
    cyc(1); chk("lit_step0", an, 4'b1110);
    cyc(4); chk("lit_step1", an, LZB ? 4'hF : 4'b1101);
    cyc(4); chk("lit_step2", an, 4'b1011);
    cyc(4); chk("lit_step3", an, LZB ? 4'hF : 4'b0111);
    cyc(4); chk("lit_step4", an, 4'b1110);

    p1_tens = 4'd0; p1_ones = 4'd7; p2_tens = 4'd0; p2_ones = 4'd3;
    cyc(2);
    wait_an(4'b1110, "w_p2ones");
    chk("lit_seg3", seg, 7'h30);
    wait_an(4'b1011, "w_p1ones");
    chk("lit_seg7", seg, 7'h78);
    chk("lit_dp", dp, 1'b0);
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (an[3] == 1'b0) lows++;
    end
    chk("lit_lz_blank", lows, 0);
`else
    lows = 0;
    wait_an(4'b0111, "w_p1tens");
    chk("lit_tens0", seg, 7'h40);
`endif

    p2_ones = 4'hC;
    cyc(2);
    wait_an(4'b1110, "w_dash");
    chk("lit_dash", seg, 7'h3F);
    cyc(10);
    chk("lit_dash_nowin", game_over, 1'b0);

    p1_tens = 4'd0; p1_ones = 4'd9;
    cyc(3);
    p1_tens = 4'd1; p1_ones = 4'd0;
    cyc(1); chk("lit_go_early", game_over, 1'b0);
    cyc(1); chk("lit_go", game_over, 1'b1);
    chk("lit_win_p1", winner, 2'b01);
    cyc(30);
    p2_tens = 4'd1; p2_ones = 4'd2;
    cyc(60);
    chk("lit_win_kept", winner, 2'b01);

    reset = 1'b1;
    p1_tens = 4'd0; p1_ones = 4'd0; p2_tens = 4'd0; p2_ones = 4'd0;
    cyc(1);
    chk("lit_mid_an", an, 4'hF);
    chk("lit_mid_seg", seg, 7'h7F);
    chk("lit_mid_dp", dp, 1'b1);
    chk("lit_mid_go", game_over, 1'b0);
    chk("lit_mid_win", winner, 2'b00);
    reset = 1'b0;
    cyc(1); chk("lit_restart", an, 4'b1110);

    cyc(5);
    p1_tens = 4'd1; p1_ones = 4'd0; p2_tens = 4'd1; p2_ones = 4'd0;
    cyc(2);
    chk("lit_draw", winner, 2'b11);
    cyc(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
